writeback_unit: RTL

Writeback sequencer for the multicycle RV32I core. It drives the register file's write port (`rd`, `wb_op`, `wb_data`) at the end of each instruction:
- selects the result source;
- waits for memory on loads;
- performs byte/halfword extraction and sign/zero extension;
- presents exactly one single-cycle write per instruction.

It sits between the control FSM and memory on one side and the register file on the other.

---
 rtl/writeback_unit_pkg.sv | 24 ++
 rtl/load_extend.sv | 54 +++++
 rtl/writeback_unit.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/writeback_unit_pkg.sv
// Shared definitions for the writeback sequencer: writeback source codes,
// load funct3 codes and the sequencer state encoding.
package writeback_unit_pkg;

  localparam logic [2:0] WB_ALU   = 3'd0;
  localparam logic [2:0] WB_MEM   = 3'd1;
  localparam logic [2:0] WB_PC4   = 3'd2;
  localparam logic [2:0] WB_IMM   = 3'd3;
  localparam logic [2:0] WB_AUIPC = 3'd4;
  localparam logic [2:0] WB_NONE  = 3'd7;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_MEM,
    WRITE
  } wb_state_t;

endpackage

// File: rtl/load_extend.sv
// Combinational load formatter: picks the addressed byte/halfword out of the
// memory word, extends it per funct3 and flags misaligned accesses.
module load_extend
  import writeback_unit_pkg::*;
(
  input  logic [31:0] mem_rdata,
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  output logic [31:0] ext_data,
  output logic        misalign
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = mem_rdata[7:0];
    case (off)
      2'd0: byte_sel = mem_rdata[7:0];
      2'd1: byte_sel = mem_rdata[15:8];
      2'd2: byte_sel = mem_rdata[23:16];
      2'd3: byte_sel = mem_rdata[31:24];
      default: byte_sel = mem_rdata[7:0];
    endcase
    half_sel = off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
  end

  // Unknown funct3 codes behave exactly like LW, including the alignment rule.
  always_comb begin
    ext_data = mem_rdata;
    misalign = 1'b0;
    case (funct3)
      F3_LB: begin
        ext_data = {{24{byte_sel[7]}}, byte_sel};
      end
      F3_LBU: begin
        ext_data = {24'd0, byte_sel};
      end
      F3_LH: begin
        ext_data = {{16{half_sel[15]}}, half_sel};
        misalign = off[0];
      end
      F3_LHU: begin
        ext_data = {16'd0, half_sel};
        misalign = off[0];
      end
      default: begin
        ext_data = mem_rdata;
        misalign = (off != 2'd0);
      end
    endcase
  end

endmodule

// File: rtl/writeback_unit.sv
// Writeback sequencer: selects the result source, waits for memory on loads
// and presents exactly one single-cycle register file write per instruction.
module writeback_unit
  import writeback_unit_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  wb_sel,
  input  logic [4:0]  rd_in,
  input  logic [2:0]  funct3,
  input  logic [31:0] alu_result,
  input  logic [31:0] pc,
  input  logic [31:0] imm,
  input  logic [31:0] mem_rdata,
  input  logic        mem_valid,
  output logic [4:0]  rd,
  output logic [2:0]  wb_op,
  output logic [31:0] wb_data,
  output logic        busy,
  output logic        done,
  output logic        misalign
);

  wb_state_t   state, state_n;
  logic [4:0]  rd_q, rd_q_n;
  logic [2:0]  funct3_q, funct3_q_n;
  logic [1:0]  off_q, off_q_n;
  logic        mis_q, mis_q_n;

  logic [4:0]  rd_n;
  logic [2:0]  wb_op_n;
  logic [31:0] wb_data_n;
  logic        done_n, misalign_n;

  logic [31:0] src_data;
  logic [2:0]  src_op;
  logic [1:0]  ext_off;
  logic [2:0]  ext_funct3;
  logic [31:0] ext_data;
  logic        ext_misalign;

  // The single formatter sees the live request in IDLE (alignment check on
  // entry) and the latched request in WAIT_MEM (data extraction).
  assign ext_off    = (state == IDLE) ? alu_result[1:0] : off_q;
  assign ext_funct3 = (state == IDLE) ? funct3 : funct3_q;

  load_extend u_load_extend (
    .mem_rdata (mem_rdata),
    .off       (ext_off),
    .funct3    (ext_funct3),
    .ext_data  (ext_data),
    .misalign  (ext_misalign)
  );

  always_comb begin
    src_data = 32'd0;
    src_op   = WB_NONE;
    case (wb_sel)
      WB_ALU:   begin src_data = alu_result; src_op = WB_ALU;   end
      WB_PC4:   begin src_data = pc + 32'd4; src_op = WB_PC4;   end
      WB_IMM:   begin src_data = imm;        src_op = WB_IMM;   end
      WB_AUIPC: begin src_data = pc + imm;   src_op = WB_AUIPC; end
      default:  begin src_data = 32'd0;      src_op = WB_NONE;  end
    endcase
  end

  // Next-state and next-output logic; outputs default to the idle pattern so
  // the register file only sees a write while in WRITE.
  always_comb begin
    state_n    = state;
    rd_q_n     = rd_q;
    funct3_q_n = funct3_q;
    off_q_n    = off_q;
    mis_q_n    = mis_q;
    rd_n       = 5'd0;
    wb_op_n    = WB_NONE;
    wb_data_n  = 32'd0;
    done_n     = 1'b0;
    misalign_n = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (wb_sel == WB_MEM) begin
            state_n    = WAIT_MEM;
            rd_q_n     = rd_in;
            funct3_q_n = funct3;
            off_q_n    = alu_result[1:0];
            mis_q_n    = ext_misalign;
          end else begin
            state_n   = WRITE;
            rd_n      = rd_in;
            wb_data_n = src_data;
            wb_op_n   = (rd_in == 5'd0) ? WB_NONE : src_op;
            done_n    = 1'b1;
          end
        end
      end
      WAIT_MEM: begin
        if (mem_valid) begin
          state_n    = WRITE;
          rd_n       = rd_q;
          wb_data_n  = ext_data;
          wb_op_n    = (mis_q || rd_q == 5'd0) ? WB_NONE : WB_MEM;
          done_n     = 1'b1;
          misalign_n = mis_q;
          mis_q_n    = 1'b0;
        end
      end
      WRITE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      rd_q     <= 5'd0;
      funct3_q <= 3'd0;
      off_q    <= 2'd0;
      mis_q    <= 1'b0;
      rd       <= 5'd0;
      wb_op    <= WB_NONE;
      wb_data  <= 32'd0;
      busy     <= 1'b0;
      done     <= 1'b0;
      misalign <= 1'b0;
    end else begin
      state    <= state_n;
      rd_q     <= rd_q_n;
      funct3_q <= funct3_q_n;
      off_q    <= off_q_n;
      mis_q    <= mis_q_n;
      rd       <= rd_n;
      wb_op    <= wb_op_n;
      wb_data  <= wb_data_n;
      busy     <= (state_n != IDLE);
      done     <= done_n;
      misalign <= misalign_n;
    end
  end

endmodule
